// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the L1 I-cache and D-cache.
// One transaction is in flight at a time; the response goes back only to its owner.
module l1_l2_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned LINE_W   = 128,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              grant_d
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;
    logic              ireq, dreq;

    assign ireq = icache_pmem_read;
    assign dreq = dcache_pmem_read | dcache_pmem_write;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        unique case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time is granted.
                if (dreq && (!ireq || !last_d_q)) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = dcache_pmem_address & LINE_MASK;
                    op_wr_d  = dcache_pmem_write;
                    if (dcache_pmem_write) begin
                        wdata_d = dcache_pmem_wdata;
                    end
                end else if (ireq) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = icache_pmem_address & LINE_MASK;
                    op_wr_d  = 1'b0;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    irdata_d = l2_rdata;
                    state_d  = IDLE;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    drdata_d = l2_rdata;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign l2_read    = (state_q != IDLE) && !op_wr_q;
    assign l2_write   = (state_q != IDLE) && op_wr_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign grant_d    = (state_q == SERVE_D);

    // Responses bypass the hold registers so the requester sees data in the resp cycle.
    assign icache_pmem_resp  = (state_q == SERVE_I) && l2_resp;
    assign dcache_pmem_resp  = (state_q == SERVE_D) && l2_resp;
    assign icache_pmem_rdata = icache_pmem_resp ? l2_rdata : irdata_q;
    assign dcache_pmem_rdata = dcache_pmem_resp ? l2_rdata : drdata_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_l1_l2_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              icache_pmem_read = 1'b0;
    logic [ADDR_W-1:0] icache_pmem_address = '0;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read = 1'b0;
    logic              dcache_pmem_write = 1'b0;
    logic [ADDR_W-1:0] dcache_pmem_address = '0;
    logic [LINE_W-1:0] dcache_pmem_wdata = '0;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata = '0;
    logic              l2_resp = 1'b0;
    logic              grant_d;

    l1_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .l2_read             (l2_read),
        .l2_write            (l2_write),
        .l2_address          (l2_address),
        .l2_wdata            (l2_wdata),
        .l2_rdata            (l2_rdata),
        .l2_resp             (l2_resp),
        .grant_d             (grant_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
    int              m_owner = 0;
    bit              m_wr = 1'b0;
    bit              m_last_d = 1'b0;
    logic [15:0]     m_addr = '0;
    logic [127:0]    m_wdata = '0;
    logic [127:0]    m_ird = '0;
    logic [127:0]    m_drd = '0;

    function automatic int pick_owner(input bit ir, input bit dr, input bit last_d);
        if (ir && dr) return last_d ? 1 : 2;
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner  <= 0;
            m_wr     <= 1'b0;
            m_last_d <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_ird    <= '0;
            m_drd    <= '0;
        end else if (m_owner == 0) begin
            case (pick_owner(icache_pmem_read, dcache_pmem_read | dcache_pmem_write, m_last_d))
                1: begin
                    m_owner  <= 1;
                    m_wr     <= 1'b0;
                    m_last_d <= 1'b0;
                    m_addr   <= icache_pmem_address & 16'hFFF0;
                end
                2: begin
                    m_owner  <= 2;
                    m_wr     <= dcache_pmem_write;
                    m_last_d <= 1'b1;
                    m_addr   <= dcache_pmem_address & 16'hFFF0;
                    if (dcache_pmem_write) m_wdata <= dcache_pmem_wdata;
                end
                default: ;
            endcase
        end else if (l2_resp) begin
            if (m_owner == 1) m_ird <= l2_rdata;
            else m_drd <= l2_rdata;
            m_owner <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_l2_read", l2_read, m_owner != 0 && !m_wr);
            chk("m_l2_write", l2_write, m_owner != 0 && m_wr);
            chk("m_l2_address", l2_address, m_addr);
            chk("m_l2_wdata", l2_wdata, m_wdata);
            chk("m_grant_d", grant_d, m_owner == 2);
            chk("m_i_resp", icache_pmem_resp, m_owner == 1 && l2_resp);
            chk("m_d_resp", dcache_pmem_resp, m_owner == 2 && l2_resp);
            chk("m_i_rdata", icache_pmem_rdata, (m_owner == 1 && l2_resp) ? l2_rdata : m_ird);
            chk("m_d_rdata", dcache_pmem_rdata, (m_owner == 2 && l2_resp) ? l2_rdata : m_drd);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] wd;
        bit found;
        int exp_grant;

        a5 = {16{8'hA5}};
        wd = 128'h0123456789ABCDEF0123456789ABCDEF;

        step();
        step();
        chk_on = 1'b1;
        #4;
        chk("rst_l2_read", l2_read, 1'b0);
        chk("rst_l2_write", l2_write, 1'b0);
        chk("rst_grant_d", grant_d, 1'b0);
        chk("rst_l2_address", l2_address, 16'h0000);
        chk("rst_i_rdata", icache_pmem_rdata, 128'h0);
        step();
        reset_n = 1'b1;

        // I-cache read of 0x1234
        step();
        icache_pmem_read = 1'b1;
        icache_pmem_address = 16'h1234;
        step();
        icache_pmem_read = 1'b0;
        #4;
        chk("i_l2_read", l2_read, 1'b1);
        chk("i_l2_address", l2_address, 16'h1230);
        chk("i_grant_d", grant_d, 1'b0);
        step();
        step();
        l2_resp = 1'b1;
        l2_rdata = a5;
        #4;
        chk("i_resp", icache_pmem_resp, 1'b1);
        chk("i_rdata", icache_pmem_rdata, a5);
        chk("i_no_dresp", dcache_pmem_resp, 1'b0);
        step();
        l2_resp = 1'b0;
        l2_rdata = '0;
        #4;
        chk("i_resp_pulse", icache_pmem_resp, 1'b0);
        chk("i_idle_read", l2_read, 1'b0);
        chk("i_rdata_hold", icache_pmem_rdata, a5);

        // D-cache writeback of 0x2008, wdata changes mid-serve
        step();
        dcache_pmem_write = 1'b1;
        dcache_pmem_address = 16'h2008;
        dcache_pmem_wdata = wd;
        step();
        dcache_pmem_write = 1'b0;
        dcache_pmem_wdata = ~wd;
        #4;
        chk("d_l2_write", l2_write, 1'b1);
        chk("d_l2_read", l2_read, 1'b0);
        chk("d_l2_address", l2_address, 16'h2000);
        chk("d_l2_wdata", l2_wdata, wd);
        chk("d_grant_d", grant_d, 1'b1);
        step();
        #4;
        chk("d_wdata_stable", l2_wdata, wd);
        step();
        l2_resp = 1'b1;
        l2_rdata = 128'h5555;
        #4;
        chk("d_resp", dcache_pmem_resp, 1'b1);
        chk("d_no_iresp", icache_pmem_resp, 1'b0);
        step();
        l2_resp = 1'b0;

        // l2_resp while idle with no request
        step();
        l2_resp = 1'b1;
        l2_rdata = 128'hFEED;
        #4;
        chk("idle_i_resp", icache_pmem_resp, 1'b0);
        chk("idle_d_resp", dcache_pmem_resp, 1'b0);
        chk("idle_i_rdata", icache_pmem_rdata, a5);
        step();
        l2_resp = 1'b0;
        #4;
        chk("idle_stay_read", l2_read, 1'b0);
        chk("idle_stay_grant", grant_d, 1'b0);

        // Reset asserted while serving a D writeback
        step();
        dcache_pmem_write = 1'b1;
        dcache_pmem_address = 16'h3004;
        dcache_pmem_wdata = wd;
        step();
        dcache_pmem_write = 1'b0;
        #4;
        chk("rd_l2_write_pre", l2_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rd_l2_write_async", l2_write, 1'b0);
        chk("rd_grant_async", grant_d, 1'b0);
        chk("rd_addr_async", l2_address, 16'h0000);
        step();
        reset_n = 1'b1;
        icache_pmem_read = 1'b1;
        icache_pmem_address = 16'h4444;
        step();
        icache_pmem_read = 1'b0;
        #4;
        chk("rd_fresh_i_read", l2_read, 1'b1);
        chk("rd_fresh_i_addr", l2_address, 16'h4440);
        chk("rd_fresh_grant_d", grant_d, 1'b0);
        step();
        l2_resp = 1'b1;
        step();
        l2_resp = 1'b0;

        // Both requesters held for 6 transactions from reset: D, I, D, I, D, I
        do_reset();
        icache_pmem_read = 1'b1;
        icache_pmem_address = 16'h0100;
        dcache_pmem_read = 1'b1;
        dcache_pmem_address = 16'h0200;
        for (int t = 0; t < 6; t++) begin
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                step();
                #4;
                found = l2_read | l2_write;
            end
            chk("tie_wait", found, 1'b1);
            exp_grant = (t % 2 == 0) ? 1 : 0;
            chk("tie_grant", grant_d, exp_grant[0]);
            step();
            l2_resp = 1'b1;
            l2_rdata = {4{$urandom}};
            #4;
            chk("tie_d_resp", dcache_pmem_resp, exp_grant[0]);
            chk("tie_i_resp", icache_pmem_resp, !exp_grant[0]);
            step();
            l2_resp = 1'b0;
        end
        icache_pmem_read = 1'b0;
        dcache_pmem_read = 1'b0;

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            reset_n = ($urandom_range(0, 299) != 0);
            icache_pmem_read = ($urandom_range(0, 2) == 0);
            icache_pmem_address = ADDR_W'($urandom);
            dcache_pmem_read = ($urandom_range(0, 2) == 0);
            dcache_pmem_write = ($urandom_range(0, 3) == 0);
            dcache_pmem_address = ADDR_W'($urandom);
            dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            l2_resp = ($urandom_range(0, 2) == 0);
        end
        step();
        reset_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
